// File: rtl/ecc_25_scrub_ctrl_pkg.sv
// Shared types and constants for the 25-bit SEC-DED scrubber.
// Code: Hamming positions 1..30 (check bits at powers of two), parity[5] = overall parity.
package ecc_25_scrub_ctrl_pkg;

  localparam int DATA_W = 25;
  localparam int PAR_W  = 6;
  localparam int CNT_W  = 16;
  localparam int WORD_W = DATA_W + PAR_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_CHECK,
    ST_WRITE
  } scrub_state_e;

  // Hamming codeword position of data bit idx (3,5,6,7,9,... skipping powers of two)
  function automatic logic [4:0] data_pos(input int idx);
    int n;
    n = 0;
    data_pos = 5'd0;
    for (int p = 3; p < 31; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == idx) data_pos = 5'(p);
        n++;
      end
    end
  endfunction

endpackage

// File: rtl/ecc_25_cal.sv
// SEC-DED parity generator: five Hamming check bits plus overall parity for 25 data bits.
module ecc_25_cal
  import ecc_25_scrub_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [PAR_W-1:0]  parity
);

  logic [4:0] h;

  always_comb begin
    h = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (data[i]) h = h ^ data_pos(i);
    end
    parity = {(^data) ^ (^h), h};
  end

endmodule

// File: rtl/ecc_25_scrub_ctrl.sv
// Background ECC scrubber: walks the RAM, corrects single-bit errors in place and
// reports double-bit errors, yielding the RAM port to user traffic at all times.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | scrubbing disabled
// ST_WAIT  | counting idle cycles before the next step
// ST_READ  | waiting for a free port to read scrub_ptr
// ST_CHECK | read data valid, syndrome evaluated
// ST_WRITE | waiting for a free port to write back the fix
module ecc_25_scrub_ctrl
  import ecc_25_scrub_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 6,
  parameter int SCRUB_INTERVAL = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scrub_en,
  input  logic                  user_re,
  input  logic                  user_we,
  input  logic [ADDR_WIDTH-1:0] user_addr,
  input  logic [WORD_W-1:0]     user_wdata,
  output logic                  ram_re,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WORD_W-1:0]     ram_wdata,
  input  logic [WORD_W-1:0]     ram_rdata,
  output logic                  scrub_busy,
  output logic                  pass_done,
  output logic                  dbit_irq,
  output logic [ADDR_WIDTH-1:0] dbit_addr,
  output logic [CNT_W-1:0]      sbit_cnt,
  output logic [CNT_W-1:0]      dbit_cnt
);

  localparam int WAIT_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [WAIT_W-1:0]     WAIT_LOAD = WAIT_W'(SCRUB_INTERVAL - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  scrub_state_e state, state_nxt;
  logic [ADDR_WIDTH-1:0] scrub_ptr;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [WORD_W-1:0]     word_q;

  logic [DATA_W-1:0] rd_data, fix_data;
  logic [PAR_W-1:0]  rd_par, chk_par, fix_par;
  logic [4:0]        syn;
  logic              ovr, err_single, err_double;
  logic              port_free, user_hit;
  logic              advance, latch_fix, inc_sbit, inc_dbit, load_wait;

  assign rd_data = ram_rdata[DATA_W-1:0];
  assign rd_par  = ram_rdata[WORD_W-1:DATA_W];

  ecc_25_cal u_chk (.data(rd_data),  .parity(chk_par));
  ecc_25_cal u_enc (.data(fix_data), .parity(fix_par));

  // Syndrome 31 has no codeword position, so an odd error there is uncorrectable
  assign syn        = chk_par[4:0] ^ rd_par[4:0];
  assign ovr        = (^chk_par) ^ (^rd_par);
  assign err_single = ovr && (syn != 5'd31);
  assign err_double = (!ovr && (syn != 5'd0)) || (ovr && (syn == 5'd31));

  always_comb begin
    fix_data = rd_data;
    for (int i = 0; i < DATA_W; i++) begin
      if (err_single && (syn == data_pos(i))) fix_data[i] = ~rd_data[i];
    end
  end

  assign port_free  = !user_re && !user_we;
  assign user_hit   = user_we && (user_addr == scrub_ptr);
  assign scrub_busy = (state == ST_READ) || (state == ST_CHECK) || (state == ST_WRITE);

  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    latch_fix = 1'b0;
    inc_sbit  = 1'b0;
    inc_dbit  = 1'b0;
    load_wait = 1'b0;
    case (state)
      ST_IDLE: begin
        if (scrub_en) begin
          state_nxt = ST_WAIT;
          load_wait = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!scrub_en)              state_nxt = ST_IDLE;
        else if (wait_cnt == '0)    state_nxt = ST_READ;
      end
      ST_READ: begin
        if (!scrub_en)              state_nxt = ST_IDLE;
        else if (port_free)         state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (!scrub_en) begin
          state_nxt = ST_IDLE;
        end else if (err_double) begin
          inc_dbit = 1'b1;
          advance  = 1'b1;
        end else if (err_single) begin
          inc_sbit = 1'b1;
          if (user_hit) begin
            advance = 1'b1;
          end else begin
            latch_fix = 1'b1;
            state_nxt = ST_WRITE;
          end
        end else begin
          advance = 1'b1;
        end
      end
      ST_WRITE: begin
        if (user_hit || port_free) advance = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (advance) begin
      state_nxt = scrub_en ? ST_WAIT : ST_IDLE;
      load_wait = scrub_en;
    end
  end

  always_comb begin
    if (!port_free) begin
      ram_re    = user_re;
      ram_we    = user_we;
      ram_addr  = user_addr;
      ram_wdata = user_wdata;
    end else begin
      ram_re    = (state == ST_READ) && scrub_en;
      ram_we    = (state == ST_WRITE);
      ram_addr  = scrub_ptr;
      ram_wdata = word_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      scrub_ptr <= '0;
      wait_cnt  <= '0;
      word_q    <= '0;
      sbit_cnt  <= '0;
      dbit_cnt  <= '0;
      dbit_addr <= '0;
      pass_done <= 1'b0;
      dbit_irq  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pass_done <= advance && (scrub_ptr == LAST_ADDR);
      dbit_irq  <= inc_dbit;
      if (load_wait)                               wait_cnt <= WAIT_LOAD;
      else if ((state == ST_WAIT) && (wait_cnt != '0)) wait_cnt <= wait_cnt - 1'b1;
      if (advance)   scrub_ptr <= scrub_ptr + 1'b1;
      if (latch_fix) word_q    <= {fix_par, fix_data};
      if (inc_sbit && (sbit_cnt != '1)) sbit_cnt <= sbit_cnt + 1'b1;
      if (inc_dbit) begin
        if (dbit_cnt != '1) dbit_cnt <= dbit_cnt + 1'b1;
        dbit_addr <= scrub_ptr;
      end
    end
  end

endmodule
